// File: rtl/xform_job_ctrl.sv
// Buffer transform job controller: reads len bytes from base, writes each back XORed with MASK.
// Optional completed-job counter on jobs_o is built only when XFORM_JOB_COUNT_EN is defined.
module xform_job_ctrl #(
    parameter logic [7:0] MASK    = 8'hAA,
    parameter logic [7:0] MAX_LEN = 8'd255
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       start_i,
    input  logic [7:0] base_i,
    input  logic [7:0] len_i,
    input  logic       abort_i,
    output logic       rd_en_o,
    output logic [7:0] rd_addr_o,
    input  logic [7:0] rd_data_i,
    output logic       wr_en_o,
    output logic [7:0] wr_addr_o,
    output logic [7:0] wr_data_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic [1:0] state_o,
    output logic [7:0] jobs_o
);

    localparam int unsigned W = 8;
    localparam logic [W:0] MAX_LEN_X = {1'b0, MAX_LEN};

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACTIVE = 2'b01,
        S_DONE   = 2'b10,
        S_ERROR  = 2'b11
    } state_e;

    state_e         state_q, state_d;
    logic           rd_en_q, rd_en_d;
    logic [W-1:0]   rd_addr_q, rd_addr_d;
    logic [W-1:0]   rem_q, rem_d;
    logic           wr_en_q, wr_en_d;
    logic [W-1:0]   wr_addr_q, wr_addr_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;
    logic           err_q, err_d;
    logic           len_bad_c;
    logic           rd_fire_c;

    assign len_bad_c = (len_i == '0) || ({1'b0, len_i} > MAX_LEN_X);

    // Abort must kill the read strobe in the same cycle, so it gates the registered strobe.
    assign rd_fire_c = rd_en_q & ~abort_i;

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rem_d     = rem_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (len_bad_c) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d   = S_ACTIVE;
                        rd_en_d   = 1'b1;
                        rd_addr_d = base_i;
                        rem_d     = len_i;
                    end
                end
            end
            S_ACTIVE: begin
                wr_en_d   = rd_fire_c;
                wr_addr_d = rd_addr_q;
                if (abort_i) begin
                    state_d = S_ERROR;
                end else if (rd_en_q) begin
                    rem_d     = W'(rem_q - W'(1));
                    rd_addr_d = W'(rd_addr_q + W'(1));
                    rd_en_d   = (rem_q != W'(1));
                end else begin
                    // trailing write of the last byte is on the bus this cycle
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERROR: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_ACTIVE) || (state_d == S_DONE);
        err_d  = (state_d == S_ERROR);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= S_IDLE;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rem_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            rem_q     <= rem_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

`ifdef XFORM_JOB_COUNT_EN
    logic [W-1:0] jobs_q, jobs_d;

    assign jobs_d = done_d ? W'(jobs_q + W'(1)) : jobs_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            jobs_q <= '0;
        end else begin
            jobs_q <= jobs_d;
        end
    end

    assign jobs_o = jobs_q;
`else
    assign jobs_o = 8'h00;
`endif

    assign rd_en_o   = rd_fire_c;
    assign rd_addr_o = rd_addr_q;
    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    // Read data arrives the cycle after the strobe, so the write data is formed on the fly.
    assign wr_data_o = wr_en_q ? (rd_data_i ^ MASK) : 8'h00;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign state_o   = state_q;

endmodule
